// File: rtl/apb_initiator.sv
// rtl/apb_initiator.sv - single-outstanding APB initiator bridge with response timeout
module apb_initiator #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_write,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ADDR_WIDTH-1:0] paddr,
  output logic                  psel,
  output logic                  penable,
  output logic                  pwrite,
  output logic [DATA_WIDTH-1:0] pwdata,
  input  logic [DATA_WIDTH-1:0] prdata,
  input  logic                  pready
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESPONSE} state_t;

  localparam bit         TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                state, state_nxt;
  logic [7:0]            tmo_cnt, tmo_cnt_nxt;
  logic [ADDR_WIDTH-1:0] paddr_nxt;
  logic [DATA_WIDTH-1:0] pwdata_nxt, rsp_rdata_nxt;
  logic                  psel_nxt, penable_nxt, pwrite_nxt;
  logic                  rsp_valid_nxt, rsp_timeout_nxt;

  assign req_ready = (state == IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      tmo_cnt     <= '0;
      paddr       <= '0;
      pwdata      <= '0;
      pwrite      <= 1'b0;
      psel        <= 1'b0;
      penable     <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      tmo_cnt     <= tmo_cnt_nxt;
      paddr       <= paddr_nxt;
      pwdata      <= pwdata_nxt;
      pwrite      <= pwrite_nxt;
      psel        <= psel_nxt;
      penable     <= penable_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_rdata   <= rsp_rdata_nxt;
      rsp_timeout <= rsp_timeout_nxt;
    end
  end

  always_comb begin
    state_nxt       = state;
    tmo_cnt_nxt     = tmo_cnt;
    paddr_nxt       = paddr;
    pwdata_nxt      = pwdata;
    pwrite_nxt      = pwrite;
    psel_nxt        = psel;
    penable_nxt     = penable;
    rsp_valid_nxt   = rsp_valid;
    rsp_rdata_nxt   = rsp_rdata;
    rsp_timeout_nxt = rsp_timeout;
    case (state)
      IDLE: begin
        if (req_valid) begin
          paddr_nxt  = req_addr;
          pwrite_nxt = req_write;
          pwdata_nxt = req_wdata;
          psel_nxt   = 1'b1;
          state_nxt  = SETUP;
        end
      end
      SETUP: begin
        penable_nxt = 1'b1;
        tmo_cnt_nxt = '0;
        state_nxt   = ACCESS;
      end
      ACCESS: begin
        // pready is checked first so a completion on the last allowed cycle is not aborted
        if (pready) begin
          psel_nxt        = 1'b0;
          penable_nxt     = 1'b0;
          rsp_rdata_nxt   = pwrite ? '0 : prdata;
          rsp_timeout_nxt = 1'b0;
          rsp_valid_nxt   = 1'b1;
          state_nxt       = RESPONSE;
        end else begin
          tmo_cnt_nxt = tmo_cnt + 8'd1;
          if (TMO_EN && (tmo_cnt == TMO_LAST)) begin
            psel_nxt        = 1'b0;
            penable_nxt     = 1'b0;
            rsp_rdata_nxt   = '0;
            rsp_timeout_nxt = 1'b1;
            rsp_valid_nxt   = 1'b1;
            state_nxt       = RESPONSE;
          end
        end
      end
      RESPONSE: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_apb_initiator.sv
// tb/tb_apb_initiator.sv - self-checking bench for apb_initiator with a cycle-timing transfer model
module tb_apb_initiator;

  localparam int T = 4;

  logic        clk, rst;
  logic        req_valid, req_ready, req_write;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_timeout;
  logic [7:0]  rsp_rdata;
  logic [15:0] paddr;
  logic        psel, penable, pwrite, pready;
  logic [7:0]  pwdata, prdata;

  apb_initiator #(.ADDR_WIDTH(16), .DATA_WIDTH(8), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_timeout(rsp_timeout),
    .paddr(paddr), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // per-request stimulus knobs, captured by the model at acceptance
  int req_ws, req_hold;
  int xfer_wait = 0, xfer_hold = 0;

  // model of the single outstanding transfer
  logic       busy = 1'b0, live = 1'b0;
  int         m_n, m_a;
  logic       m_write, m_to;
  logic [15:0] m_addr;
  logic [7:0] m_wdata, m_rdata;
  logic [7:0] mdl_mem [0:65535];
  logic [7:0] mem     [0:65535];

  int   acc_t[$], hs_t[$];
  logic [7:0] rsp_rd[$];
  logic       rsp_to[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // APB responder: pready after xfer_wait wait states; pready held high outside ACCESS on purpose
  initial begin : responder
    int acc_seen;
    acc_seen = 0;
    pready = 1'b0;
    prdata = 8'hEE;
    forever begin
      @(negedge clk);
      if (psel && penable) begin
        pready = (acc_seen == xfer_wait);
        prdata = pwrite ? 8'hEE : mem[paddr];
        if (pready && pwrite) mem[paddr] = pwdata;
        acc_seen++;
      end else begin
        pready   = 1'b1;
        prdata   = 8'hEE;
        acc_seen = 0;
      end
    end
  end

  initial begin : consumer
    int rv_seen;
    rv_seen = 0;
    rsp_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (rsp_valid) begin
        rsp_ready = (rv_seen >= xfer_hold);
        rv_seen++;
      end else begin
        rsp_ready = 1'b1;
        rv_seen   = 0;
      end
    end
  end

  // psel spans SETUP plus A access cycles; rsp_valid follows until the handshake
  initial begin : compare
    int   c;
    logic ep, ee, ev, er;
    forever begin
      @(negedge clk);
      #1;
      if (live) begin
        if (busy) begin
          c  = cyc - m_n;
          ep = (c >= 1) && (c <= 1 + m_a);
          ee = (c >= 2) && (c <= 1 + m_a);
          ev = (c >= 2 + m_a);
          er = 1'b0;
        end else begin
          ep = 1'b0; ee = 1'b0; ev = 1'b0; er = 1'b1;
        end
        check("psel", 32'(psel), 32'(ep));
        check("penable", 32'(penable), 32'(ee));
        check("rsp_valid", 32'(rsp_valid), 32'(ev));
        check("req_ready", 32'(req_ready), 32'(er));
        if (ep) begin
          check("paddr", 32'(paddr), 32'(m_addr));
          check("pwrite", 32'(pwrite), 32'(m_write));
          if (m_write) check("pwdata", 32'(pwdata), 32'(m_wdata));
        end
        if (ev) begin
          check("rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
          check("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
        end
        if (!rst) begin
          if (ev && rsp_ready) begin
            rsp_rd.push_back(rsp_rdata);
            rsp_to.push_back(rsp_timeout);
            hs_t.push_back(cyc);
            busy = 1'b0;
          end else if (!busy && req_valid) begin
            m_n     = cyc;
            m_addr  = req_addr;
            m_write = req_write;
            m_wdata = req_wdata;
            if (req_ws < T) begin
              m_a = req_ws + 1; m_to = 1'b0;
            end else begin
              m_a = T; m_to = 1'b1;
            end
            m_rdata = (m_to || m_write) ? 8'h00 : mdl_mem[m_addr];
            if (m_write && !m_to) mdl_mem[m_addr] = m_wdata;
            xfer_wait = req_ws;
            xfer_hold = req_hold;
            busy = 1'b1;
            acc_t.push_back(cyc);
          end
        end
      end
      if (rst) begin
        busy = 1'b0;
        live = 1'b1;
      end
    end
  end

  task automatic issue(input logic [15:0] a, input logic w, input logic [7:0] d,
                       input int ws, input int hold);
    int k0, t;
    k0 = acc_t.size();
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_write = w; req_wdata = d;
    req_ws = ws; req_hold = hold;
    #2;
    t = 0;
    while (acc_t.size() == k0 && t < 200) begin
      @(negedge clk); #2; t++;
    end
    check("accept_wait", 32'(acc_t.size() != k0), 32'd1);
  endtask

  task automatic drop();
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy && t < 200) begin
      @(negedge clk); #2; t++;
    end
    check("idle_wait", 32'(!busy), 32'd1);
  endtask

  initial begin : stim
    int i0, r0, t;
    logic [7:0] wd;
    for (int a = 0; a < 65536; a++) begin
      mem[a] = 8'h00; mdl_mem[a] = 8'h00;
    end
    mem[16'h0103] = 8'hA5; mdl_mem[16'h0103] = 8'hA5;
    mem[16'h0200] = 8'h3C; mdl_mem[16'h0200] = 8'h3C;
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_write = 1'b0; req_wdata = '0;
    req_ws = 0; req_hold = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #2;
    check("reset_paddr", 32'(paddr), 32'h0);
    check("reset_pwdata", 32'(pwdata), 32'h0);
    check("reset_pwrite", 32'(pwrite), 32'h0);
    check("reset_rsp_rdata", 32'(rsp_rdata), 32'h0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'h0);

    // read, zero wait states
    i0 = acc_t.size(); r0 = rsp_rd.size();
    issue(16'h0103, 1'b0, 8'h00, 0, 0); drop(); wait_idle();
    check("t1_rdata", 32'(rsp_rd[r0]), 32'hA5);
    check("t1_timeout", 32'(rsp_to[r0]), 32'h0);
    check("t1_latency", 32'(hs_t[r0] - acc_t[i0]), 32'd3);

    // write with 3 wait states, then read it back
    i0 = acc_t.size(); r0 = rsp_rd.size();
    issue(16'h0000, 1'b1, 8'h5C, 3, 0); drop(); wait_idle();
    check("t2_rdata", 32'(rsp_rd[r0]), 32'h00);
    check("t2_timeout", 32'(rsp_to[r0]), 32'h0);
    check("t2_latency", 32'(hs_t[r0] - acc_t[i0]), 32'd6);
    issue(16'h0000, 1'b0, 8'h00, 1, 0); drop(); wait_idle();
    check("t2_readback", 32'(rsp_rd[r0+1]), 32'h5C);

    // timeout, then a normal read
    i0 = acc_t.size(); r0 = rsp_rd.size();
    issue(16'h0300, 1'b0, 8'h00, 255, 0); drop(); wait_idle();
    check("t3_rdata", 32'(rsp_rd[r0]), 32'h00);
    check("t3_timeout", 32'(rsp_to[r0]), 32'h1);
    check("t3_latency", 32'(hs_t[r0] - acc_t[i0]), 32'd6);
    issue(16'h0200, 1'b0, 8'h00, 0, 0); drop(); wait_idle();
    check("t3_next_rdata", 32'(rsp_rd[r0+1]), 32'h3C);
    check("t3_next_timeout", 32'(rsp_to[r0+1]), 32'h0);

    // pready on the last cycle before abort wins
    r0 = rsp_rd.size();
    issue(16'h0103, 1'b0, 8'h00, T - 1, 0); drop(); wait_idle();
    check("edge_rdata", 32'(rsp_rd[r0]), 32'hA5);
    check("edge_timeout", 32'(rsp_to[r0]), 32'h0);

    // response backpressure with a queued request
    i0 = acc_t.size(); r0 = rsp_rd.size();
    issue(16'h0200, 1'b0, 8'h00, 0, 5);
    issue(16'h0103, 1'b0, 8'h00, 0, 0); drop(); wait_idle();
    check("t4_hold_latency", 32'(hs_t[r0] - acc_t[i0]), 32'd8);
    check("t4_next_accept", 32'(acc_t[i0+1] - hs_t[r0]), 32'd1);
    check("t4_rdata0", 32'(rsp_rd[r0]), 32'h3C);
    check("t4_rdata1", 32'(rsp_rd[r0+1]), 32'hA5);

    // reset during ACCESS
    r0 = rsp_rd.size();
    issue(16'h0101, 1'b0, 8'h00, 10, 0); drop();
    t = 0;
    while (!penable && t < 50) begin
      @(negedge clk); #2; t++;
    end
    check("t5_penable_seen", 32'(penable), 32'h1);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #2;
    check("t5_psel", 32'(psel), 32'h0);
    check("t5_penable", 32'(penable), 32'h0);
    check("t5_rsp_valid", 32'(rsp_valid), 32'h0);
    check("t5_paddr", 32'(paddr), 32'h0);
    repeat (8) @(negedge clk);
    #2;
    check("t5_no_response", 32'(rsp_rd.size()), 32'(r0));

    // back-to-back alternating write/read stream
    i0 = acc_t.size(); r0 = rsp_rd.size();
    for (int i = 0; i < 8; i++) begin
      wd = 8'((i + 1) * 17);
      if (i % 2 == 0) issue(16'h0100, 1'b1, wd, 0, 0);
      else            issue(16'h0100, 1'b0, 8'h00, 0, 0);
    end
    drop(); wait_idle();
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) check("t6_write_rdata", 32'(rsp_rd[r0+i]), 32'h00);
      else            check("t6_read_rdata", 32'(rsp_rd[r0+i]), 32'(8'(i * 17)));
      if (i < 7) check("t6_spacing", 32'(acc_t[i0+i+1] - acc_t[i0+i]), 32'd4);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
